// File: rtl/verilog_bm_152_246_pkg.sv
// verilog_bm_152_246_pkg
//   Shared types and constants for the two-digit BCD counter with 7-segment
//   display drive and segment readback.
//   - bcd_t      : one BCD digit (4 bits, valid range 0-9)
//   - seg_t      : segment vector [0:6], index 0 = a ... index 6 = g
//   - SEG_*      : logical (active-high) segment patterns for digits 0-9
//   - SEG_BLANK  : all segments off, used for codes 10-15
//   - BCD_ERR    : readback code for any pattern that is not a digit
package verilog_bm_152_246_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [0:6] seg_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_ERR = 4'hF;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/verilog_bm_152_246_bcd_to_seg7.sv
// bcd_to_seg7
//   Combinational BCD to logical (active-high) 7-segment encoder.
//   Codes 10-15 produce a blank display.
//   Ports:
//     bcd_i : input digit
//     seg_o : segments a..g, index 0 = a
module bcd_to_seg7
  import verilog_bm_152_246_pkg::*;
(
  input  bcd_t bcd_i,
  output seg_t seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/verilog_bm_152_246.sv
// verilog_bm_152_246
//   Two-digit BCD up-counter (00-99, wraps) driving a two-digit 7-segment
//   display, with a readback path that recovers each digit from its segments.
//   Ports:
//     clk      : system clock, rising edge
//     reset    : asynchronous active-low reset
//     counter1 : units digit (BCD)
//     counter2 : tens digit (BCD)
//     decoder1 : segments a..g for the units digit
//     decoder2 : segments a..g for the tens digit
//     out1     : digit recovered from the units segment pattern (F = not a digit)
//     out2     : digit recovered from the tens segment pattern  (F = not a digit)
//   Build option:
//     SEG_ACTIVE_LOW_EN : when defined, decoder1/decoder2 are inverted for
//                         common-anode displays. Readback is unaffected.
module verilog_bm_152_246
  import verilog_bm_152_246_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] counter1,
  output logic [3:0] counter2,
  output logic [0:6] decoder1,
  output logic [0:6] decoder2,
  output logic [3:0] out1,
  output logic [3:0] out2
);

  bcd_t counter1_q, counter1_d;
  bcd_t counter2_q, counter2_d;
  seg_t seg1_log, seg2_log;

  // Reverse decode of a logical segment pattern; anything else, blank
  // included, reports the error code.
  function automatic bcd_t seg_to_bcd(input seg_t seg);
    bcd_t d;
    case (seg)
      SEG_0:   d = 4'd0;
      SEG_1:   d = 4'd1;
      SEG_2:   d = 4'd2;
      SEG_3:   d = 4'd3;
      SEG_4:   d = 4'd4;
      SEG_5:   d = 4'd5;
      SEG_6:   d = 4'd6;
      SEG_7:   d = 4'd7;
      SEG_8:   d = 4'd8;
      SEG_9:   d = 4'd9;
      default: d = BCD_ERR;
    endcase
    return d;
  endfunction

  // Next-state: an out-of-range digit is forced to 0 on the next edge.
  // The tens digit advances only when the units digit is exactly 9.
  always_comb begin
    bcd_t tens_hold;
    tens_hold  = (counter2_q > BCD_MAX) ? 4'd0 : counter2_q;
    counter1_d = 4'd0;
    counter2_d = tens_hold;
    if (counter1_q == BCD_MAX) begin
      counter1_d = 4'd0;
      counter2_d = (counter2_q >= BCD_MAX) ? 4'd0 : counter2_q + 4'd1;
    end else if (counter1_q < BCD_MAX) begin
      counter1_d = counter1_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter1_q <= 4'd0;
      counter2_q <= 4'd0;
    end else begin
      counter1_q <= counter1_d;
      counter2_q <= counter2_d;
    end
  end

  bcd_to_seg7 u_seg_units (
    .bcd_i (counter1_q),
    .seg_o (seg1_log)
  );

  bcd_to_seg7 u_seg_tens (
    .bcd_i (counter2_q),
    .seg_o (seg2_log)
  );

`ifdef SEG_ACTIVE_LOW_EN
  assign decoder1 = ~seg1_log;
  assign decoder2 = ~seg2_log;
`else
  assign decoder1 = seg1_log;
  assign decoder2 = seg2_log;
`endif

  // Readback works on the logical pattern so it is polarity independent.
  assign out1     = seg_to_bcd(seg1_log);
  assign out2     = seg_to_bcd(seg2_log);

  assign counter1 = counter1_q;
  assign counter2 = counter2_q;

endmodule

// File: tb/tb_verilog_bm_152_246.sv
module tb_verilog_bm_152_246;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] counter1, counter2, out1, out2;
  logic [0:6] decoder1, decoder2;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] seg_tbl [0:9];

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [6:0] POL = 7'h7F;
`else
  localparam logic [6:0] POL = 7'h00;
`endif

  verilog_bm_152_246 dut (
    .clk      (clk),
    .reset    (reset),
    .counter1 (counter1),
    .counter2 (counter2),
    .decoder1 (decoder1),
    .decoder2 (decoder2),
    .out1     (out1),
    .out2     (out2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_state(input int cnt);
    int u, t;
    u = cnt % 10;
    t = cnt / 10;
    chk("counter1", {28'd0, counter1}, u);
    chk("counter2", {28'd0, counter2}, t);
    chk("out1", {28'd0, out1}, u);
    chk("out2", {28'd0, out2}, t);
    chk("decoder1", {25'd0, decoder1}, {25'd0, seg_tbl[u] ^ POL});
    chk("decoder2", {25'd0, decoder2}, {25'd0, seg_tbl[t] ^ POL});
  endtask

  initial begin
    seg_tbl[0] = 7'b1111110;
    seg_tbl[1] = 7'b0110000;
    seg_tbl[2] = 7'b1101101;
    seg_tbl[3] = 7'b1111001;
    seg_tbl[4] = 7'b0110011;
    seg_tbl[5] = 7'b1011011;
    seg_tbl[6] = 7'b1011111;
    seg_tbl[7] = 7'b1110000;
    seg_tbl[8] = 7'b1111111;
    seg_tbl[9] = 7'b1111011;

    // Held in reset across clock edges
    reset = 1'b0;
    #12;
    check_state(0);
    chk("rst_dec1", {25'd0, decoder1}, {25'd0, 7'b1111110 ^ POL});

    @(negedge clk);
    reset = 1'b1;

    // Full count 1..99, checking every value
    for (int k = 1; k <= 99; k++) begin
      @(posedge clk);
      #1;
      check_state(k);
      if (k == 8) begin
        chk("c08_dec1", {25'd0, decoder1}, {25'd0, 7'b1111111 ^ POL});
        chk("c08_dec2", {25'd0, decoder2}, {25'd0, 7'b1111110 ^ POL});
        chk("c08_out", {24'd0, out2, out1}, 32'h08);
      end
      if (k == 10)
        chk("c10_dec2", {25'd0, decoder2}, {25'd0, 7'b0110000 ^ POL});
      if (k == 99) begin
        chk("c99_cnt", {24'd0, counter2, counter1}, 32'h99);
        chk("c99_dec1", {25'd0, decoder1}, {25'd0, 7'b1111011 ^ POL});
        chk("c99_dec2", {25'd0, decoder2}, {25'd0, 7'b1111011 ^ POL});
      end
    end

    // 100th edge wraps
    @(posedge clk);
    #1;
    check_state(0);
    chk("wrap_cnt", {24'd0, counter2, counter1}, 32'h00);

    // Count to 49, then reset asynchronously between edges
    for (int k = 1; k <= 49; k++) begin
      @(posedge clk);
      #1;
    end
    check_state(49);
    #1;
    reset = 1'b0;
    #1;
    check_state(0);
    chk("async_rst", {24'd0, counter2, counter1}, 32'h00);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_state(1);
    chk("no_carry", {24'd0, counter2, counter1}, 32'h01);

    // Reset at 99 clears without carry
    for (int k = 2; k <= 99; k++) begin
      @(posedge clk);
      #1;
    end
    check_state(99);
    reset = 1'b0;
    #1;
    check_state(0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_state(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
